// File: rtl/data_memory_pc.sv
// data_memory_pc: parametrised data RAM for the CPU datapath.
//   STA stores the accumulator; LDA/ADD read operands back.
//   After every reset, and on a software clear request, a sequencer writes
//   INIT_VAL to every word, one word per cycle. Accesses are ignored while
//   busy is high.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (restarts the clear sequence)
//   clear      pulse requesting re-initialisation (honoured only when idle)
//   address    word address for the access
//   acc        write data (accumulator)
//   mem_read   read strobe
//   mem_write  write strobe
//   data       read data (0 when not reading, busy, or out of range)
//   rvalid     qualifies data
//   busy       clear sequencer active
module data_memory_pc #(
   parameter int unsigned       DATA_W       = 8,
   parameter int unsigned       ADDR_W       = 4,
   parameter int unsigned       DEPTH        = 16,
   parameter int unsigned       READ_LATENCY = 0,
   parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] acc,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic [DATA_W-1:0] data,
   output logic              rvalid,
   output logic              busy
);

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_next;
   logic [DATA_W-1:0] ram [DEPTH];
   logic              in_range;
   logic              rd_ok;

   assign in_range = ({1'b0, address} < DEPTH_EXT);

   // busy is decoded from the registered state, so it still changes only on
   // clock edges exactly like a dedicated busy flop would.
   assign busy  = (state == CLEAR);
   assign rd_ok = mem_read & ~busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         CLEAR: begin
            cnt_next = cnt + 1'b1;
            if (cnt == LAST_IDX) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         IDLE: begin
            if (clear) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   // Array has no reset: the reset edge leaves contents alone and the
   // sequencer overwrites them during the following DEPTH cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            ram[cnt] <= INIT_VAL;
         end else if (mem_write && in_range) begin
            ram[address] <= acc;
         end
      end
   end

   if (READ_LATENCY == 0) begin : g_comb_read
      always_comb begin
         rvalid = rd_ok;
         data   = '0;
         if (rd_ok && in_range) begin
            data = ram[address];
         end
      end
   end else begin : g_reg_read
      // Captured on the same edge as any write, so a same-cycle write to the
      // same address is not yet visible (read-before-write).
      always_ff @(posedge clk) begin
         if (reset) begin
            rvalid <= 1'b0;
            data   <= '0;
         end else begin
            rvalid <= rd_ok;
            data   <= (rd_ok && in_range) ? ram[address] : '0;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_pc.sv
// Bench for data_memory_pc: four instances with different parameters share
// one stimulus stream; each has a behavioural model checked every cycle.
module tb_data_memory_pc;

   localparam int NI = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic [3:0] address = '0;
   logic [7:0] acc = '0;
   logic       mem_read = 1'b0;
   logic       mem_write = 1'b0;

   logic [7:0] data_w   [NI];
   logic       rvalid_w [NI];
   logic       busy_w   [NI];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   // Instance table: 0 = defaults, 1 = registered read, 2 = registered read
   // with preset 5A, 3 = twelve words with combinational read.
   function automatic int dep_of(input int i);
      return (i == 3) ? 12 : 16;
   endfunction

   function automatic bit lat_of(input int i);
      return (i == 1) || (i == 2);
   endfunction

   function automatic logic [7:0] init_of(input int i);
      return (i == 2) ? 8'h5A : 8'h00;
   endfunction

   data_memory_pc #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_LATENCY(0), .INIT_VAL(8'h00)) u_d0 (
      .clk(clk), .reset(reset), .clear(clear), .address(address), .acc(acc),
      .mem_read(mem_read), .mem_write(mem_write),
      .data(data_w[0]), .rvalid(rvalid_w[0]), .busy(busy_w[0]));

   data_memory_pc #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_LATENCY(1), .INIT_VAL(8'h00)) u_d1 (
      .clk(clk), .reset(reset), .clear(clear), .address(address), .acc(acc),
      .mem_read(mem_read), .mem_write(mem_write),
      .data(data_w[1]), .rvalid(rvalid_w[1]), .busy(busy_w[1]));

   data_memory_pc #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_LATENCY(1), .INIT_VAL(8'h5A)) u_d2 (
      .clk(clk), .reset(reset), .clear(clear), .address(address), .acc(acc),
      .mem_read(mem_read), .mem_write(mem_write),
      .data(data_w[2]), .rvalid(rvalid_w[2]), .busy(busy_w[2]));

   data_memory_pc #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .READ_LATENCY(0), .INIT_VAL(8'h00)) u_d3 (
      .clk(clk), .reset(reset), .clear(clear), .address(address), .acc(acc),
      .mem_read(mem_read), .mem_write(mem_write),
      .data(data_w[3]), .rvalid(rvalid_w[3]), .busy(busy_w[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: 'left' is the number of clear cycles still owed.
   logic [7:0] mram [NI][16];
   int         left [NI];
   bit         mrv_r [NI];
   logic [7:0] mdata_r [NI];
   bit         known = 1'b0;
   bit         rd_m;

   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (reset) begin
            left[i]    = dep_of(i);
            mrv_r[i]   = 1'b0;
            mdata_r[i] = 8'h00;
         end else begin
            rd_m       = mem_read && (left[i] == 0);
            mrv_r[i]   = rd_m;
            mdata_r[i] = (rd_m && address < dep_of(i)) ? mram[i][address] : 8'h00;
            if (left[i] > 0) begin
               mram[i][dep_of(i) - left[i]] = init_of(i);
               left[i]--;
            end else begin
               if (mem_write && address < dep_of(i)) mram[i][address] = acc;
               if (clear) left[i] = dep_of(i);
            end
         end
      end
      if (reset) known = 1'b1;
   end

   logic [7:0] ed_c;
   bit         erv_c;

   always @(negedge clk) begin
      if (known) begin
         for (int i = 0; i < NI; i++) begin
            erv_c = lat_of(i) ? mrv_r[i] : (mem_read && left[i] == 0);
            ed_c  = lat_of(i) ? mdata_r[i]
                  : ((erv_c && address < dep_of(i)) ? mram[i][address] : 8'h00);
            chk($sformatf("inst%0d busy", i), 32'(busy_w[i]), 32'(left[i] > 0));
            chk($sformatf("inst%0d rvalid", i), 32'(rvalid_w[i]), 32'(erv_c));
            chk($sformatf("inst%0d data", i), 32'(data_w[i]), 32'(ed_c));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (!busy_w[0] && !busy_w[1] && !busy_w[2] && !busy_w[3]) done = 1'b1;
      end
      if (!done) chk("wait_idle timeout", 32'd1, 32'd0);
   endtask

   // Counts busy cycles of instances 0 and 3 from the current point.
   task automatic count_busy(output int n0, output int n3);
      bit done;
      n0 = 0;
      n3 = 0;
      done = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (busy_w[0]) n0++;
         if (busy_w[3]) n3++;
         if (!busy_w[0] && !busy_w[3]) done = 1'b1;
      end
   endtask

   int n0, n3, n2;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset for two cycles, then busy length per depth.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      count_busy(n0, n3);
      chk("reset busy len d16", 32'(n0), 32'd16);
      chk("reset busy len d12", 32'(n3), 32'd12);
      tick();

      // Write A5 to 3, read back in both latencies.
      address = 4'd3; acc = 8'hA5; mem_write = 1'b1;
      tick();
      mem_write = 1'b0; mem_read = 1'b1;
      @(negedge clk);
      chk("lat0 readback data", 32'(data_w[0]), 32'hA5);
      chk("lat0 readback rvalid", 32'(rvalid_w[0]), 32'd1);
      tick();
      mem_read = 1'b0;
      @(negedge clk);
      chk("lat1 readback data", 32'(data_w[1]), 32'hA5);
      chk("lat1 readback rvalid", 32'(rvalid_w[1]), 32'd1);
      tick();
      @(negedge clk);
      chk("lat1 after data", 32'(data_w[1]), 32'h00);
      chk("lat1 after rvalid", 32'(rvalid_w[1]), 32'd0);

      // Same-cycle read and write to address 5.
      tick();
      address = 4'd5; acc = 8'h11; mem_write = 1'b1;
      tick();
      acc = 8'h22; mem_read = 1'b1;
      tick();
      mem_write = 1'b0;
      @(negedge clk);
      chk("rbw lat1 old", 32'(data_w[1]), 32'h11);
      chk("rbw lat0 new", 32'(data_w[0]), 32'h22);
      tick();
      @(negedge clk);
      chk("rbw lat1 new", 32'(data_w[1]), 32'h22);
      tick();
      mem_read = 1'b0;

      // Out-of-range address on the twelve-word instance.
      address = 4'd13; acc = 8'h77; mem_write = 1'b1;
      tick();
      mem_write = 1'b0; mem_read = 1'b1;
      @(negedge clk);
      chk("oor d12 data", 32'(data_w[3]), 32'h00);
      chk("oor d12 rvalid", 32'(rvalid_w[3]), 32'd1);
      chk("oor d16 data", 32'(data_w[0]), 32'h77);
      tick();
      mem_read = 1'b0;

      // Access during busy: write FF to 0 on clear cycle 4.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      tick();
      address = 4'd0; acc = 8'hFF; mem_write = 1'b1; mem_read = 1'b1;
      @(negedge clk);
      chk("busy access rvalid", 32'(rvalid_w[0]), 32'd0);
      chk("busy access data", 32'(data_w[0]), 32'h00);
      tick();
      mem_write = 1'b0; mem_read = 1'b0;
      wait_idle();
      tick();
      address = 4'd0; mem_read = 1'b1;
      @(negedge clk);
      chk("after busy ram0 d0", 32'(data_w[0]), 32'h00);
      tick();
      mem_read = 1'b0;
      @(negedge clk);
      chk("after busy ram0 d2", 32'(data_w[2]), 32'h5A);

      // Fill, software clear, second clear pulse mid-sequence.
      tick();
      for (int a = 0; a < 16; a++) begin
         address = 4'(a); acc = 8'(a * 16 + 3); mem_write = 1'b1;
         tick();
      end
      mem_write = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n2 = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy_w[2]) break;
         n2++;
         clear = (n2 == 5);
      end
      clear = 1'b0;
      chk("sw clear busy len", 32'(n2), 32'd16);
      wait_idle();
      tick();
      for (int a = 0; a < 16; a++) begin
         address = 4'(a); mem_read = 1'b1;
         tick();
         @(negedge clk);
         chk($sformatf("preset word %0d", a), 32'(data_w[2]), 32'h5A);
         chk($sformatf("zero word %0d", a), 32'(data_w[0]), 32'h00);
      end
      mem_read = 1'b0;

      // Reset on clear cycle 6 restarts the full sequence.
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      count_busy(n0, n3);
      chk("midclear reset len d16", 32'(n0), 32'd16);
      chk("midclear reset len d12", 32'(n3), 32'd12);

      // Randomised traffic against the model.
      tick();
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         clear     = ($urandom_range(0, 63) == 0);
         mem_write = 1'($urandom_range(0, 1));
         mem_read  = 1'($urandom_range(0, 1));
         address   = 4'($urandom_range(0, 15));
         acc       = 8'($urandom_range(0, 255));
         tick();
      end
      reset = 1'b0; clear = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
      tick();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/data_memory_pc.md
Name: data_memory_pc

Overview:
- Parametrised data RAM for the CPU datapath; stores the accumulator on STA and returns operands on LDA/ADD.
- Adds four things a plain RAM lacks: configurable width and depth, selectable read latency, a hardware clear sequencer, and a busy flag.
- The clear sequencer runs after every reset and on a software request. It zeroes (or presets) the array one word per cycle; the controller must hold off memory accesses while busy is high.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- READ_LATENCY, 0: 0 = combinational read, 1 = registered read; any other value is illegal.
- INIT_VAL, 0: DATA_W-bit value written to every word by the clear sequencer.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- clear, input, 1: pulse requesting an array re-initialisation.
- address, input, ADDR_W: word address for the access.
- acc, input, DATA_W: write data (the accumulator value).
- mem_read, input, 1: read strobe, active high.
- mem_write, input, 1: write strobe, active high.
- data, output, DATA_W: read data.
- rvalid, output, 1: qualifies data.
- busy, output, 1: clear sequencer active; accesses are ignored while high.

Behaviour:
- FSM has two states, CLEAR and IDLE. A counter cnt of ADDR_W bits, or wider if DEPTH needs it, drives the sequencer.
- Reset (clock edge with reset=1):
  - state<=CLEAR, cnt<=0, busy<=1.
  - Registered data<=0, rvalid<=0.
  - RAM contents are untouched by the reset edge itself.
- CLEAR state, each edge with reset=0:
  - ram[cnt]<=INIT_VAL and cnt<=cnt+1.
  - On the edge where cnt==DEPTH-1: state<=IDLE, busy<=0.
  - Result: busy stays high for exactly DEPTH edges after reset deasserts.
- An access is accepted only in a cycle where busy==0.
  - While busy==1, mem_read and mem_write are ignored.
  - data reads 0 and rvalid reads 0 while busy==1.
- Write: in IDLE, if mem_write=1 and address<DEPTH, then ram[address]<=acc at the clock edge. Writes with address>=DEPTH are dropped.
- Read, READ_LATENCY=0:
  - Purely combinational: rvalid = mem_read & ~busy.
  - data = ram[address] when rvalid=1 and address<DEPTH, otherwise 0.
- Read, READ_LATENCY=1:
  - At each edge: rvalid <= mem_read & ~busy, and data <= ram[address] (or 0 when out of range or not reading).
  - Result is visible one cycle after the request; data returns to 0 the cycle after a non-read.
- Read and write to the same address in the same cycle: read-before-write in both latencies, so the read returns the old contents.
  - Latency 0: data shows the old value until the edge, then the new value if mem_read is still high.
- clear=1 while in IDLE:
  - Any write in that same cycle is still performed.
  - Next edge: state<=CLEAR, cnt<=0, busy<=1, and the clear then overwrites the array.
  - Latency 1: the read accepted that cycle still completes, so rvalid pulses on the following cycle.
- clear=1 while in CLEAR: ignored; the sequence continues without restarting.
- reset asserted mid-clear: the sequence restarts from cnt=0 and runs the full DEPTH cycles.
- reset has priority over clear and over all accesses.
- Out-of-range addresses only occur when DEPTH < 2**ADDR_W. The sequencer never touches indices >= DEPTH.

Test Plan:
- Reset then idle, defaults: assert reset for 2 cycles, release -> busy=1 for exactly 16 cycles, then 0; every location reads 8'h00; data=0, rvalid=0 throughout the busy period.
- Write then read back, READ_LATENCY=0: write acc=8'hA5 to address 3, next cycle mem_read at address 3 -> data=8'hA5 with rvalid=1 in the same cycle. Repeat with READ_LATENCY=1 -> data=8'hA5 and rvalid=1 one cycle later, then 0.
- Same-cycle read and write: ram[5]=8'h11; in one cycle write 8'h22 to address 5 with mem_read=1 -> READ_LATENCY=1 returns 8'h11; the following read returns 8'h22.
- Access during busy: issue mem_write of 8'hFF to address 0 at cycle 4 of the clear -> ignored, rvalid=0; after busy falls, ram[0]=INIT_VAL.
- Software clear with INIT_VAL=8'h5A: fill all words, pulse clear -> busy for 16 cycles; all words read 8'h5A. Pulsing clear again mid-sequence does not extend busy beyond 16 cycles.
- DEPTH=12, ADDR_W=4, and reset mid-clear: write to address 13 is dropped and a read of address 13 returns 0 with rvalid=1. Assert reset at clear cycle 6 -> busy lasts a full 12 cycles after release.
